redun_mont_host: RTL

REDUN_MONT_HOST -- requirements
Module: redun_mont_host

---
 rtl/redun_mont_pkg.sv | 20 ++
 rtl/redun_word_resolve.sv | 18 +
 rtl/redun_mont_host.sv | 126 ++++++++++++
 3 files changed

// File: rtl/redun_mont_pkg.sv
// Shared types and sizing for the Montgomery squaring host: redundant-form
// operand, FSM state encoding and carry width.
package redun_mont_pkg;
  localparam int WRD_BITS   = 16;
  localparam int NUM_WRDS   = 4;
  localparam int ITER_W_DEF = 64;
  // Each word holds WRD_BITS+1 bits plus an incoming carry of at most 2, so
  // the outgoing carry never exceeds 2.
  localparam int CARRY_W    = 2;
  localparam int IDX_W      = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_RUN  = 4'b0100,
    ST_OUT  = 4'b1000
  } host_st_e;
endpackage

// File: rtl/redun_word_resolve.sv
// One step of carry resolution: redundant word plus carry in gives a
// canonical word and the carry out for the next word.
module redun_word_resolve
  import redun_mont_pkg::*;
(
  input  logic [WRD_BITS:0]    word_in,
  input  logic [CARRY_W-1:0]   carry_in,
  output logic [WRD_BITS-1:0]  word_out,
  output logic [CARRY_W-1:0]   carry_out
);
  logic [WRD_BITS+1:0] sum;

  always_comb begin
    sum       = {1'b0, word_in} + {{WRD_BITS{1'b0}}, carry_in};
    word_out  = sum[WRD_BITS-1:0];
    carry_out = sum[WRD_BITS+1:WRD_BITS];
  end
endmodule

// File: rtl/redun_mont_host.sv
// Host sequencer for a redundant-form Montgomery squarer: loads a start
// value, counts squarings, then streams the result out in canonical binary.
module redun_mont_host
  import redun_mont_pkg::*;
#(
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  redun0_t             i_sq_in,
  input  logic [ITER_W-1:0]   i_iter,
  output logic                o_busy,
  output logic                o_sq_rst,
  output redun0_t             o_sq,
  output logic                o_sq_val,
  input  redun0_t             i_mul,
  input  logic                i_mul_val,
  output logic [WRD_BITS-1:0] o_dat,
  output logic                o_dat_val,
  input  logic                i_dat_rdy,
  output logic                o_dat_last,
  output logic                o_ovf
);
  host_st_e            st, nxt;
  logic                load_ph;
  logic [ITER_W-1:0]   iter_r, cnt;
  logic [CARRY_W-1:0]  carry;
  logic [IDX_W-1:0]    idx;
  redun0_t             sq_r;

  logic                start_ok, mul_hit, beat, load_word;
  logic [WRD_BITS-1:0] res_word;
  logic [CARRY_W-1:0]  res_carry;

  always_comb begin
    nxt      = st;
    start_ok = 1'b0;
    mul_hit  = 1'b0;
    case (st)
      ST_IDLE: if (i_start) begin
        start_ok = 1'b1;
        nxt      = (i_iter == '0) ? ST_OUT : ST_LOAD;
      end
      ST_LOAD: if (load_ph) nxt = ST_RUN;
      ST_RUN: if (i_mul_val && cnt == iter_r - ITER_W'(1)) begin
        mul_hit = 1'b1;
        nxt     = ST_OUT;
      end
      ST_OUT: if (o_dat_val && i_dat_rdy && o_dat_last) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
    beat      = o_dat_val && i_dat_rdy;
    // Fetch a word on entry to OUT and after each non-final accepted beat.
    load_word = (st == ST_OUT) && (!o_dat_val || (beat && !o_dat_last));
  end

  assign o_sq_val = (st == ST_LOAD) && load_ph;
  assign o_sq     = sq_r;

  redun_word_resolve u_resolve (
    .word_in   (sq_r[idx]),
    .carry_in  (carry),
    .word_out  (res_word),
    .carry_out (res_carry)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st         <= ST_IDLE;
      load_ph    <= 1'b0;
      o_sq_rst   <= 1'b1;
      o_busy     <= 1'b0;
      o_dat_val  <= 1'b0;
      o_dat_last <= 1'b0;
      o_ovf      <= 1'b0;
      cnt        <= '0;
      carry      <= '0;
      idx        <= '0;
    end else begin
      st <= nxt;
      if (start_ok) begin
        o_busy   <= 1'b1;
        o_ovf    <= 1'b0;
        o_sq_rst <= (i_iter == '0);
        load_ph  <= 1'b0;
        carry    <= '0;
        idx      <= '0;
      end
      if (st == ST_LOAD) load_ph <= ~load_ph;
      if (st == ST_LOAD && load_ph) cnt <= '0;
      if (st == ST_RUN && i_mul_val) begin
        if (mul_hit) begin
          o_sq_rst <= 1'b1;
          carry    <= '0;
          idx      <= '0;
        end else begin
          cnt <= cnt + ITER_W'(1);
        end
      end
      if (load_word) begin
        carry      <= res_carry;
        idx        <= idx + IDX_W'(1);
        o_dat_val  <= 1'b1;
        o_dat_last <= (idx == IDX_W'(NUM_WRDS-1));
      end
      if (beat && o_dat_last) begin
        o_ovf      <= |carry;
        o_busy     <= 1'b0;
        o_dat_val  <= 1'b0;
        o_dat_last <= 1'b0;
      end
    end
  end

  // Operand, iteration count and output word carry no reset.
  always_ff @(posedge i_clk) begin
    if (start_ok) begin
      sq_r   <= i_sq_in;
      iter_r <= i_iter;
    end else if (mul_hit) begin
      sq_r <= i_mul;
    end
    if (load_word) o_dat <= res_word;
  end
endmodule
